// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider.
// - DivWidth : default operand/result width
// - div_state_e : 3-bit FSM state encoding used by div_seq
package div_seq_pkg;

    localparam int unsigned DivWidth = 32;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StIter  = 3'd2,
        StFix   = 3'd3,
        StDone  = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division step. This block is purely combinational.
// Ports:
//   rem_i     partial remainder (always < divisor_i between steps)
//   quo_i     dividend bits still to shift in, with quotient bits filling from bit 0
//   divisor_i divisor magnitude
//   rem_o     next partial remainder
//   quo_o     next dividend/quotient word
module div_seq_step
    import div_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DivWidth
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    // The shifted remainder needs one extra bit; the difference always fits in WIDTH bits.
    logic [WIDTH:0] rem_sh;
    logic           ge;

    always_comb begin
        rem_sh = {rem_i, quo_i[WIDTH-1]};
        ge     = (rem_sh >= {1'b0, divisor_i});
        rem_o  = ge ? (rem_sh[WIDTH-1:0] - divisor_i) : rem_sh[WIDTH-1:0];
        quo_o  = {quo_i[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/div_seq.sv
// Sequential signed divider, responder side of the div start/done handshake.
// Quotient truncates toward zero; remainder takes the sign of the dividend.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   div_ctrl  start request, sampled only while idle
//   a_in      dividend (two's complement)
//   b_in      divisor (two's complement)
//   hi_out    remainder, updated only when a division completes normally
//   lo_out    quotient, updated only when a division completes normally
//   div_end   one-cycle completion pulse
//   div_zero  divisor was zero; only ever high together with div_end
//   busy      high from the cycle after start until div_end falls
module div_seq
    import div_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DivWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_ctrl,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_end,
    output logic             div_zero,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH);

    div_state_e       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] bmag_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [CntW-1:0]  count_q;

    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    div_seq_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(bmag_q),
        .rem_o    (rem_next),
        .quo_o    (quo_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            bmag_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            count_q   <= '0;
            hi_out    <= '0;
            lo_out    <= '0;
            div_end   <= 1'b0;
            div_zero  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (div_ctrl) begin
                        a_q  <= a_in;
                        b_q  <= b_in;
                        busy <= 1'b1;
                        if (b_in == '0) begin
                            // Skip the iteration entirely; results keep their old values.
                            div_end  <= 1'b1;
                            div_zero <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            state_q <= StSetup;
                        end
                    end
                end
                StSetup: begin
                    quo_q     <= a_q[WIDTH-1] ? -a_q : a_q;
                    bmag_q    <= b_q[WIDTH-1] ? -b_q : b_q;
                    rem_q     <= '0;
                    neg_quo_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
                    neg_rem_q <= a_q[WIDTH-1];
                    count_q   <= CntW'(WIDTH - 1);
                    state_q   <= StIter;
                end
                StIter: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    if (count_q == '0) begin
                        state_q <= StFix;
                    end else begin
                        count_q <= count_q - CntW'(1);
                    end
                end
                StFix: begin
                    // -2^31 / -1 wraps back to 0x80000000 naturally here.
                    lo_out  <= neg_quo_q ? -quo_q : quo_q;
                    hi_out  <= neg_rem_q ? -rem_q : rem_q;
                    div_end <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    div_end  <= 1'b0;
                    div_zero <= 1'b0;
                    busy     <= 1'b0;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        div_ctrl = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_end;
    logic        div_zero;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_seq u_dut (
        .clk     (clk),
        .reset   (reset),
        .div_ctrl(div_ctrl),
        .a_in    (a_in),
        .b_in    (b_in),
        .hi_out  (hi_out),
        .lo_out  (lo_out),
        .div_end (div_end),
        .div_zero(div_zero),
        .busy    (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Start one division and watch 40 samples (k=0 is #1 after the start edge E0).
    // exp_k is the sample index at which div_end must be seen.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input logic exp_zero, input int exp_k);
        int          first_k = -1;
        int          pulses = 0;
        logic [31:0] lo_c = '0;
        logic [31:0] hi_c = '0;
        logic        z_c = 1'b0;
        logic        stray = 1'b0;
        @(negedge clk);
        a_in     = a;
        b_in     = b;
        div_ctrl = 1'b1;
        @(posedge clk);
        #1;
        div_ctrl = 1'b0;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (div_end) begin
                pulses++;
                if (first_k < 0) begin
                    first_k = k;
                    lo_c    = lo_out;
                    hi_c    = hi_out;
                    z_c     = div_zero;
                end
            end else if (div_zero) begin
                stray = 1'b1;
            end
        end
        check({tag, "_end_cycle"}, 32'(first_k), 32'(exp_k));
        check({tag, "_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_lo"}, lo_c, exp_lo);
        check({tag, "_hi"}, hi_c, exp_hi);
        check({tag, "_zero"}, 32'(z_c), 32'(exp_zero));
        check({tag, "_zero_stray"}, 32'(stray), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          first_k;
        int          second_k;
        int          pulses;
        logic [31:0] lo1, hi1, lo2, hi2;
        logic        saw_end;

        // Reset state
        #12;
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        check("rst_end", 32'(div_end), 32'd0);
        check("rst_zero", 32'(div_zero), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Basic signs; completion seen at sample 34 (cycle E0+35)
        run_div("p7_p2", 32'd7, 32'd2, 32'h0000_0003, 32'h0000_0001, 1'b0, 34);
        run_div("m7_p2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
        run_div("p7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 34);
        run_div("m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0, 34);

        // Divide by zero keeps the previous results
        run_div("p9_p4", 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 34);
        run_div("p5_z", 32'd5, 32'd0, 32'd2, 32'd1, 1'b1, 0);

        // Overflow wrap and small dividend
        run_div("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34);
        run_div("p3_p10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 34);
        run_div("m3_p10", 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, 1'b0, 34);

        // div_ctrl held high; operands change mid-run; back-to-back restart
        first_k  = -1;
        second_k = -1;
        pulses   = 0;
        lo1 = '0; hi1 = '0; lo2 = '0; hi2 = '0;
        @(negedge clk);
        a_in     = 32'd20;
        b_in     = 32'd3;
        div_ctrl = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 80; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (k == 4) begin
                a_in = 32'd50;
                b_in = 32'd7;
            end
            if (k == 36) div_ctrl = 1'b0;
            if (div_end) begin
                pulses++;
                if (first_k < 0) begin
                    first_k = k;
                    lo1 = lo_out;
                    hi1 = hi_out;
                end else if (second_k < 0) begin
                    second_k = k;
                    lo2 = lo_out;
                    hi2 = hi_out;
                end
            end
        end
        check("hold_first_k", 32'(first_k), 32'd34);
        check("hold_first_lo", lo1, 32'd6);
        check("hold_first_hi", hi1, 32'd2);
        check("hold_second_k", 32'(second_k), 32'd70);
        check("hold_second_lo", lo2, 32'd7);
        check("hold_second_hi", hi2, 32'd1);
        check("hold_pulses", 32'(pulses), 32'd2);
        check("hold_busy_end", 32'(busy), 32'd0);

        // Reset mid-operation
        saw_end = 1'b0;
        @(negedge clk);
        a_in     = 32'd1000;
        b_in     = 32'd3;
        div_ctrl = 1'b1;
        @(posedge clk);
        #1;
        div_ctrl = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (div_end) saw_end = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_hi", hi_out, 32'd0);
        check("abort_lo", lo_out, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_end", 32'(div_end), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (div_end) saw_end = 1'b1;
        end
        check("abort_no_end", 32'(saw_end), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);

        run_div("p100_p7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
